// File: rtl/store_stage.sv
// Store (writeback) stage: retires execute-stage results into the register file,
// the memory write bus, or a fetch redirect, and counts retired instructions.
module store_stage #(
    parameter int CORE_ID = 0,
    parameter int ADDR_W  = 21,
    parameter int DATA_W  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [1:0]        ex_op,
    input  logic [4:0]        ex_reg,
    input  logic [DATA_W-1:0] ex_value,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [1:0]        ex_size,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_ack,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       retired_count,
    output logic              misalign_err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEM_REQ = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;

    localparam logic [1:0] OP_NOP    = 2'd0;
    localparam logic [1:0] OP_REG_WB = 2'd1;
    localparam logic [1:0] OP_STORE  = 2'd2;
    localparam logic [1:0] OP_JUMP   = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              take;
    logic              aligned;
    logic              store_go;
    logic              ack_done;
    logic              retire;
    logic [2:0]        offset;
    logic [15:0]       mask_wide;
    logic [DATA_W-1:0] wdata_shifted;

    assign take     = ex_valid && ex_ready;
    assign offset   = ex_addr[2:0];
    assign store_go = take && (ex_op == OP_STORE) && aligned;
    assign ack_done = (state == ST_MEM_REQ) && mem_ack;
    assign retire   = ack_done || (take && (ex_op != OP_STORE));

    // Aligned when the byte offset is a multiple of the access size.
    always_comb begin
        aligned = 1'b0;
        case (ex_size)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = (offset[0] == 1'b0);
            2'd2:    aligned = (offset[1:0] == 2'b00);
            default: aligned = (offset == 3'b000);
        endcase
    end

    assign mask_wide     = ((16'd1 << (4'd1 << ex_size)) - 16'd1) << offset;
    assign wdata_shifted = ex_value << {offset, 3'b000};

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (take && (ex_op == OP_JUMP)) state_nxt = ST_FLUSH;
                else if (store_go)              state_nxt = ST_MEM_REQ;
            end
            ST_MEM_REQ: if (mem_ack) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            ex_ready       <= 1'b0;
            rf_we          <= 1'b0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
            mem_req        <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_wmask      <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            retired_count  <= '0;
            misalign_err   <= 1'b0;
        end else begin
            state          <= state_nxt;
            ex_ready       <= (state_nxt == ST_IDLE);
            rf_we          <= take && (ex_op == OP_REG_WB);
            redirect_valid <= take && (ex_op == OP_JUMP);

            if (take && (ex_op == OP_REG_WB)) begin
                rf_waddr <= ex_reg;
                rf_wdata <= ex_value;
            end
            if (take && (ex_op == OP_JUMP)) redirect_pc <= ex_value[ADDR_W-1:0];

            // Store outputs are captured once and held until the bus acknowledges.
            if (store_go) begin
                mem_req   <= 1'b1;
                mem_addr  <= {ex_addr[ADDR_W-1:3], 3'b000};
                mem_wdata <= wdata_shifted;
                mem_wmask <= mask_wide[7:0];
            end else if (ack_done) begin
                mem_req <= 1'b0;
            end

            if (take && (ex_op == OP_STORE) && !aligned) misalign_err <= 1'b1;
            if (retire) retired_count <= retired_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_store_stage.sv
// Bench for store_stage: directed literal cases plus randomized traffic checked
// every cycle against a transaction-level model of the stage.
module tb_store_stage;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ex_valid = 1'b0;
    logic              ex_ready;
    logic [1:0]        ex_op = '0;
    logic [4:0]        ex_reg = '0;
    logic [DATA_W-1:0] ex_value = '0;
    logic [ADDR_W-1:0] ex_addr = '0;
    logic [1:0]        ex_size = '0;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [7:0]        mem_wmask;
    logic              mem_ack = 1'b0;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [31:0]       retired_count;
    logic              misalign_err;

    always #5 clk = ~clk;

    store_stage #(.CORE_ID(0), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_reg(ex_reg),
        .ex_value(ex_value), .ex_addr(ex_addr), .ex_size(ex_size),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_ack(mem_ack),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .retired_count(retired_count), .misalign_err(misalign_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_aligned(input logic [ADDR_W-1:0] a, input logic [1:0] s);
        int nbytes = 1 << s;
        return (int'(a[2:0]) % nbytes) == 0;
    endfunction

    function automatic logic [7:0] lane_mask(input logic [ADDR_W-1:0] a, input logic [1:0] s);
        logic [7:0] m = '0;
        int off = int'(a[2:0]);
        int nbytes = 1 << s;
        for (int b = 0; b < 8; b++)
            if (b >= off && b < off + nbytes) m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] lane_data(input logic [ADDR_W-1:0] a, input logic [63:0] v);
        logic [63:0] d = '0;
        int off = int'(a[2:0]);
        for (int b = 0; b < 8; b++)
            if (b >= off) d[8*b +: 8] = v[8*(b-off) +: 8];
        return d;
    endfunction

    logic              m_ready = 1'b0, m_rf_we = 1'b0, m_redir = 1'b0, m_req = 1'b0, m_err = 1'b0;
    logic [4:0]        m_rf_waddr = '0;
    logic [DATA_W-1:0] m_rf_wdata = '0, m_wdata = '0;
    logic [ADDR_W-1:0] m_pc = '0, m_addr = '0;
    logic [7:0]        m_wmask = '0;
    logic [31:0]       m_count = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready <= 1'b0; m_rf_we <= 1'b0; m_redir <= 1'b0; m_req <= 1'b0; m_err <= 1'b0;
            m_rf_waddr <= '0; m_rf_wdata <= '0; m_wdata <= '0; m_pc <= '0; m_addr <= '0;
            m_wmask <= '0; m_count <= '0;
        end else begin
            m_rf_we <= 1'b0;
            m_redir <= 1'b0;
            if (m_req) begin
                if (mem_ack) begin
                    m_req   <= 1'b0;
                    m_count <= m_count + 1;
                    m_ready <= 1'b1;
                end else begin
                    m_ready <= 1'b0;
                end
            end else if (m_ready && ex_valid) begin
                case (ex_op)
                    2'd0: begin m_count <= m_count + 1; m_ready <= 1'b1; end
                    2'd1: begin
                        m_rf_we <= 1'b1; m_rf_waddr <= ex_reg; m_rf_wdata <= ex_value;
                        m_count <= m_count + 1; m_ready <= 1'b1;
                    end
                    2'd3: begin
                        m_redir <= 1'b1; m_pc <= ex_value[ADDR_W-1:0];
                        m_count <= m_count + 1; m_ready <= 1'b0;
                    end
                    default: begin
                        if (is_aligned(ex_addr, ex_size)) begin
                            m_req   <= 1'b1;
                            m_addr  <= ADDR_W'((int'(ex_addr) / 8) * 8);
                            m_wmask <= lane_mask(ex_addr, ex_size);
                            m_wdata <= lane_data(ex_addr, ex_value);
                            m_ready <= 1'b0;
                        end else begin
                            m_err   <= 1'b1;
                            m_ready <= 1'b1;
                        end
                    end
                endcase
            end else begin
                m_ready <= 1'b1;
            end
        end
    end

    // Every cycle, compare DUT outputs against the model away from the active edge.
    always @(negedge clk) begin
        check("ex_ready", 64'(ex_ready), 64'(m_ready));
        check("rf_we", 64'(rf_we), 64'(m_rf_we));
        check("redirect_valid", 64'(redirect_valid), 64'(m_redir));
        check("mem_req", 64'(mem_req), 64'(m_req));
        check("retired_count", 64'(retired_count), 64'(m_count));
        check("misalign_err", 64'(misalign_err), 64'(m_err));
        check("single_side_effect", 64'(int'(rf_we) + int'(redirect_valid) + int'(mem_req) <= 1), 64'd1);
        if (m_rf_we) begin
            check("rf_waddr", 64'(rf_waddr), 64'(m_rf_waddr));
            check("rf_wdata", 64'(rf_wdata), 64'(m_rf_wdata));
        end
        if (m_redir) check("redirect_pc", 64'(redirect_pc), 64'(m_pc));
        if (m_req) begin
            check("mem_addr", 64'(mem_addr), 64'(m_addr));
            check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
            check("mem_wmask", 64'(mem_wmask), 64'(m_wmask));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [4:0] r, input logic [63:0] v,
                         input logic [ADDR_W-1:0] a, input logic [1:0] s);
        ex_valid = 1'b1; ex_op = op; ex_reg = r; ex_value = v; ex_addr = a; ex_size = s;
    endtask

    int low;

    initial begin
        // Reset state while rst_n is held low.
        #12;
        check("rst_ex_ready", 64'(ex_ready), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_rf_we", 64'(rf_we), 64'd0);
        check("rst_redirect", 64'(redirect_valid), 64'd0);
        check("rst_count", 64'(retired_count), 64'd0);
        check("rst_err", 64'(misalign_err), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wmask", 64'(mem_wmask), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_redirect_pc", 64'(redirect_pc), 64'd0);
        rst_n = 1'b1;
        tick();
        check("ready_after_reset", 64'(ex_ready), 64'd1);

        // Three back-to-back register writebacks.
        drive(2'd1, 5'd1, 64'h11, '0, 2'd0);
        tick();
        check("wb1_we", 64'(rf_we), 64'd1);
        check("wb1_addr", 64'(rf_waddr), 64'd1);
        check("wb1_data", 64'(rf_wdata), 64'h11);
        drive(2'd1, 5'd2, 64'h22, '0, 2'd0);
        tick();
        check("wb2_we", 64'(rf_we), 64'd1);
        check("wb2_addr", 64'(rf_waddr), 64'd2);
        check("wb2_data", 64'(rf_wdata), 64'h22);
        drive(2'd1, 5'd3, 64'h33, '0, 2'd0);
        tick();
        check("wb3_we", 64'(rf_we), 64'd1);
        check("wb3_data", 64'(rf_wdata), 64'h33);
        check("wb3_count", 64'(retired_count), 64'd3);
        ex_valid = 1'b0;

        // Byte store at offset 3 acknowledged in the fifth request cycle.
        drive(2'd2, 5'd0, 64'hAB, 21'h00013, 2'd0);
        tick();
        ex_valid = 1'b0;
        check("st_req", 64'(mem_req), 64'd1);
        check("st_addr", 64'(mem_addr), 64'h10);
        check("st_mask", 64'(mem_wmask), 64'h08);
        check("st_byte", 64'(mem_wdata[31:24]), 64'hAB);
        low = 0;
        for (int i = 0; i < 20 && !ex_ready; i++) begin
            low++;
            if (low == 5) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        check("st_busy_cycles", 64'(low), 64'd5);
        check("st_req_dropped", 64'(mem_req), 64'd0);
        check("st_count", 64'(retired_count), 64'd4);

        // Misaligned word store.
        drive(2'd2, 5'd0, 64'h1234, 21'h00006, 2'd2);
        tick();
        ex_valid = 1'b0;
        check("mis_no_req", 64'(mem_req), 64'd0);
        check("mis_err", 64'(misalign_err), 64'd1);
        check("mis_count", 64'(retired_count), 64'd4);

        // Jump.
        drive(2'd3, 5'd0, 64'h1F000, '0, 2'd0);
        tick();
        ex_valid = 1'b0;
        check("jmp_valid", 64'(redirect_valid), 64'd1);
        check("jmp_pc", 64'(redirect_pc), 64'h1F000);
        check("jmp_ready", 64'(ex_ready), 64'd0);
        tick();
        check("jmp_pulse_end", 64'(redirect_valid), 64'd0);
        check("jmp_ready_back", 64'(ex_ready), 64'd1);

        // Reset in the middle of a store, then a stale acknowledge.
        drive(2'd2, 5'd0, 64'hCAFE, 21'h00108, 2'd3);
        tick();
        ex_valid = 1'b0;
        check("rstst_req", 64'(mem_req), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstst_req_async", 64'(mem_req), 64'd0);
        check("rstst_count", 64'(retired_count), 64'd0);
        check("rstst_err", 64'(misalign_err), 64'd0);
        check("rstst_ready", 64'(ex_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("rstst_ack_ignored", 64'(mem_req), 64'd0);
        check("rstst_count_after", 64'(retired_count), 64'd0);
        check("rstst_ready_after", 64'(ex_ready), 64'd1);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            ex_valid = ($urandom_range(0, 3) != 0);
            ex_op    = 2'($urandom_range(0, 3));
            ex_reg   = 5'($urandom);
            ex_value = {$urandom, $urandom};
            ex_size  = 2'($urandom_range(0, 3));
            ex_addr  = ADDR_W'($urandom);
            if ($urandom_range(0, 2) != 0) ex_addr[2:0] = ex_addr[2:0] & ~3'((1 << ex_size) - 1);
            mem_ack  = ($urandom_range(0, 2) == 0);
            if (i == 1500) rst_n = 1'b0;
            if (i == 1502) rst_n = 1'b1;
            tick();
        end
        ex_valid = 1'b0;
        mem_ack  = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
